recovery_sequencer: RTL and testbench
=====================================

Name: recovery_sequencer

Overview:
Control FSM for the half-rate recovery datapath. It sequences the flush, acquisition, locked-tracking and relock phases of the event filter, lockin and rate tracker, and drives their enables and clear. It bounds acquisition time with a retry/timeout policy and reports lock and fault status to the configuration layer. It sits beside the recovery datapath in the sys domain.

Parameters:
TIMER_WIDTH, 16, width of the acquisition/relock cycle timer and the timeout inputs.
FLUSH_CYCLES, 2, number of cycles clear_state_o is held per flush (>=1).
MAX_RETRIES, 3, number of failed acquisitions allowed before FAULT.
VIOL_LIMIT, 4, number of consecutive violating events in LOCKED that force RELOCK.

Ports:
sys_clk_i  in  1  system-domain clock
sys_rst_i  in  1  synchronous active-high reset
enable_i  in  1  recovery enable; low forces IDLE
acquire_timeout_i  in  TIMER_WIDTH  ACQUIRE timeout in cycles; 0 = no timeout
relock_timeout_i  in  TIMER_WIDTH  RELOCK timeout in cycles; 0 = no timeout
locked_in_i  in  1  lockin reports lock
rate_violation_i  in  1  lockin rate violation (single-cycle pulse)
over_freq_violation_i  in  1  event filter over-frequency pulse
under_freq_violation_i  in  1  event filter under-frequency pulse
filtered_event_i  in  1  accepted event pulse from the filter
active_rate_valid_i  in  1  rate tracker holds a valid averaged rate
lockin_en_o  out  1  lockin enable
rate_tracking_en_o  out  1  rate tracker enable
clear_state_o  out  1  clear for lockin and rate tracker
locked_o  out  1  recovered clock usable
fault_o  out  1  acquisition exhausted retries
state_o  out  3  current state code
retry_count_o  out  2  failed attempts in the current run (saturates at 3)

Behaviour:
- All outputs are Moore-decoded from registered state and counters. An input causes a state change visible one cycle later.
- Reset: state IDLE (0), all outputs 0, timer, flush counter, violation counter and retry count all 0.
- Priority each cycle: sys_rst_i > enable_i low (next state IDLE from any state, counters cleared) > per-state transitions.
- Violation, for this block, means rate_violation_i | over_freq_violation_i | under_freq_violation_i.
- IDLE (0): all enables 0. enable_i high -> FLUSH. retry_count cleared.
- FLUSH (1): clear_state_o=1, other enables 0. Held exactly FLUSH_CYCLES cycles, then ACQUIRE with timer cleared.
- ACQUIRE (2): lockin_en_o=1, rate_tracking_en_o=1. Timer increments each cycle and saturates at all-ones. Transitions, in priority order:
  - rate_violation_i -> fail.
  - locked_in_i & active_rate_valid_i -> LOCKED; retry_count cleared.
  - acquire_timeout_i != 0 and timer == acquire_timeout_i - 1 -> fail.
- fail: if retry_count == MAX_RETRIES -> FAULT; otherwise retry_count+1 -> FLUSH.
- LOCKED (3): both enables 1, locked_o=1.
  - Violation increments viol_cnt.
  - filtered_event_i with no violation in the same cycle clears viol_cnt.
  - viol_cnt reaching VIOL_LIMIT, or locked_in_i low -> RELOCK; timer and viol_cnt cleared.
- RELOCK (4): lockin_en_o=1, rate_tracking_en_o=0 (rate frozen, no clear), locked_o=0. Timer runs.
  - locked_in_i high with no violation that cycle -> LOCKED.
  - relock_timeout_i != 0 and timer == relock_timeout_i - 1 -> fail path.
- FAULT (5): fault_o=1, all enables 0. Held until enable_i low -> IDLE. fault_o clears with the state.
- Codes 6 and 7 are unreachable; if entered, go to IDLE next cycle.
- Timeout inputs are sampled every cycle. Changing a timeout mid-ACQUIRE takes effect on the next compare; a value below the current timer relies on saturation (no timeout until the next clear).

Test Plan:
- Reset, then enable_i=1 -> state 1 for 2 cycles with clear_state_o=1, then state 2 with lockin_en_o=rate_tracking_en_o=1.
- acquire_timeout_i=10, locked_in_i=1 and active_rate_valid_i=1 at ACQUIRE cycle 5 -> state 3 and locked_o=1 one cycle later, retry_count_o=0.
- acquire_timeout_i=10, never lock -> after each 10-cycle ACQUIRE, FLUSH with retry_count_o 1, 2, 3; the fourth timeout -> state 5, fault_o=1. enable_i=0 -> IDLE, fault_o=0.
- In LOCKED, 4 consecutive over_freq_violation_i pulses -> RELOCK with rate_tracking_en_o=0. Same test with 3 violations then a clean filtered_event_i -> stays LOCKED.
- In RELOCK, relock_timeout_i=8 and locked_in_i reasserted at cycle 3 -> back to LOCKED. Second run with no reassert -> FLUSH at cycle 8, retry_count_o=1.
- Simultaneous cases: rate_violation_i and lock in the same ACQUIRE cycle -> FLUSH. enable_i dropped mid-FLUSH -> IDLE next cycle. sys_rst_i asserted while LOCKED -> all outputs 0 next cycle.

Source files
------------

// File: rtl/recovery_sequencer.sv
// recovery_sequencer: control FSM for the half-rate recovery datapath.
// Sequences flush, acquisition, locked tracking and relock of the event filter,
// lockin and rate tracker. Acquisition time is bounded by a timeout and a retry budget.
//
// Ports:
//   sys_clk_i, sys_rst_i       clock, synchronous active-high reset
//   enable_i                   recovery enable; low forces IDLE
//   acquire_timeout_i          ACQUIRE timeout in cycles (0 = none)
//   relock_timeout_i           RELOCK timeout in cycles (0 = none)
//   locked_in_i                lockin reports lock
//   rate_violation_i           lockin rate violation pulse
//   over/under_freq_violation_i event filter frequency violation pulses
//   filtered_event_i           accepted event pulse
//   active_rate_valid_i        rate tracker holds a valid rate
//   lockin_en_o, rate_tracking_en_o, clear_state_o  datapath controls
//   locked_o, fault_o          status
//   state_o                    current state code
//   retry_count_o              failed acquisitions in this run (saturating)
module recovery_sequencer #(
    parameter int unsigned TIMER_WIDTH  = 16,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter int unsigned VIOL_LIMIT   = 4
) (
    input  logic                   sys_clk_i,
    input  logic                   sys_rst_i,
    input  logic                   enable_i,
    input  logic [TIMER_WIDTH-1:0] acquire_timeout_i,
    input  logic [TIMER_WIDTH-1:0] relock_timeout_i,
    input  logic                   locked_in_i,
    input  logic                   rate_violation_i,
    input  logic                   over_freq_violation_i,
    input  logic                   under_freq_violation_i,
    input  logic                   filtered_event_i,
    input  logic                   active_rate_valid_i,
    output logic                   lockin_en_o,
    output logic                   rate_tracking_en_o,
    output logic                   clear_state_o,
    output logic                   locked_o,
    output logic                   fault_o,
    output logic [2:0]             state_o,
    output logic [1:0]             retry_count_o
);

    localparam int unsigned FlushW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned ViolW  = $clog2(VIOL_LIMIT + 1);
    localparam logic [FlushW-1:0]      FlushLast = FlushW'(FLUSH_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TimerOne  = TIMER_WIDTH'(1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFlush   = 3'd1,
        StAcquire = 3'd2,
        StLocked  = 3'd3,
        StRelock  = 3'd4,
        StFault   = 3'd5
    } state_e;

    state_e                 state_q;
    logic [TIMER_WIDTH-1:0] timer_q;
    logic [FlushW-1:0]      flush_cnt_q;
    logic [ViolW-1:0]       viol_cnt_q;
    logic [1:0]             retry_q;

    logic                   viol;
    logic [TIMER_WIDTH-1:0] timer_inc;
    logic                   acq_hit, rel_hit, acq_lock, rel_lock, fail;
    logic                   retry_exhausted, viol_trip;
    logic [1:0]             retry_inc;
    logic [ViolW-1:0]       viol_next;

    assign viol      = rate_violation_i | over_freq_violation_i | under_freq_violation_i;
    assign timer_inc = (&timer_q) ? timer_q : timer_q + TimerOne;
    // A timeout below the running timer never matches; saturation keeps it from wrapping.
    assign acq_hit   = (acquire_timeout_i != '0) && (timer_q == acquire_timeout_i - TimerOne);
    assign rel_hit   = (relock_timeout_i != '0) && (timer_q == relock_timeout_i - TimerOne);
    assign acq_lock  = locked_in_i & active_rate_valid_i;
    assign rel_lock  = locked_in_i & ~viol;

    // Rate violation beats lock in ACQUIRE; lock beats timeout in both phases.
    assign fail = ((state_q == StAcquire) && (rate_violation_i || (!acq_lock && acq_hit))) ||
                  ((state_q == StRelock) && !rel_lock && rel_hit);

    assign retry_exhausted = (32'(retry_q) == MAX_RETRIES);
    assign retry_inc       = (&retry_q) ? retry_q : retry_q + 2'd1;

    always_comb begin
        viol_next = viol_cnt_q;
        if (viol) begin
            viol_next = (&viol_cnt_q) ? viol_cnt_q : viol_cnt_q + 1'b1;
        end else if (filtered_event_i) begin
            viol_next = '0;
        end
    end

    // Trip on the violation that reaches the limit, so RELOCK shows the next cycle.
    assign viol_trip = (32'(viol_next) >= VIOL_LIMIT);

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i || !enable_i) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            flush_cnt_q <= '0;
            viol_cnt_q  <= '0;
            retry_q     <= '0;
        end else if (fail) begin
            if (retry_exhausted) begin
                state_q <= StFault;
            end else begin
                state_q     <= StFlush;
                retry_q     <= retry_inc;
                flush_cnt_q <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    state_q     <= StFlush;
                    flush_cnt_q <= '0;
                    retry_q     <= '0;
                end
                StFlush: begin
                    if (flush_cnt_q == FlushLast) begin
                        state_q <= StAcquire;
                        timer_q <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                    end
                end
                StAcquire: begin
                    timer_q <= timer_inc;
                    if (acq_lock) begin
                        state_q    <= StLocked;
                        retry_q    <= '0;
                        viol_cnt_q <= '0;
                    end
                end
                StLocked: begin
                    if (!locked_in_i || viol_trip) begin
                        state_q    <= StRelock;
                        timer_q    <= '0;
                        viol_cnt_q <= '0;
                    end else begin
                        viol_cnt_q <= viol_next;
                    end
                end
                StRelock: begin
                    timer_q <= timer_inc;
                    if (rel_lock) begin
                        state_q    <= StLocked;
                        viol_cnt_q <= '0;
                    end
                end
                StFault: begin
                    state_q <= StFault;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Moore decode from registered state only.
    assign lockin_en_o        = (state_q == StAcquire) || (state_q == StLocked) ||
                                (state_q == StRelock);
    assign rate_tracking_en_o = (state_q == StAcquire) || (state_q == StLocked);
    assign clear_state_o      = (state_q == StFlush);
    assign locked_o           = (state_q == StLocked);
    assign fault_o            = (state_q == StFault);
    assign state_o            = state_q;
    assign retry_count_o      = retry_q;

endmodule

// File: tb/tb_recovery_sequencer.sv
module tb_recovery_sequencer;

    // Flag vector order: {lockin_en, rate_tracking_en, clear_state, locked, fault}
    localparam logic [4:0] FIdle   = 5'b00000;
    localparam logic [4:0] FFlush  = 5'b00100;
    localparam logic [4:0] FAcq    = 5'b11000;
    localparam logic [4:0] FLock   = 5'b11010;
    localparam logic [4:0] FRelock = 5'b10000;
    localparam logic [4:0] FFault  = 5'b00001;

    typedef struct {
        logic       rst, en, lk, vld, rv, ov, uv, fe;
        logic [2:0] st;
        logic [4:0] fl;
        logic [1:0] rc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, en, lk, rv, ov, uv, fe, vld;
    logic [15:0] acq_to, rel_to;
    logic        lockin_en, rate_en, clear_st, locked, fault;
    logic [2:0]  state;
    logic [1:0]  retry;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    recovery_sequencer #(
        .TIMER_WIDTH (16),
        .FLUSH_CYCLES(2),
        .MAX_RETRIES (3),
        .VIOL_LIMIT  (4)
    ) dut (
        .sys_clk_i             (clk),
        .sys_rst_i             (rst),
        .enable_i              (en),
        .acquire_timeout_i     (acq_to),
        .relock_timeout_i      (rel_to),
        .locked_in_i           (lk),
        .rate_violation_i      (rv),
        .over_freq_violation_i (ov),
        .under_freq_violation_i(uv),
        .filtered_event_i      (fe),
        .active_rate_valid_i   (vld),
        .lockin_en_o           (lockin_en),
        .rate_tracking_en_o    (rate_en),
        .clear_state_o         (clear_st),
        .locked_o              (locked),
        .fault_o               (fault),
        .state_o               (state),
        .retry_count_o         (retry)
    );

    function automatic vec_t mk(input logic r, e, l, v, a, o, u, f,
                                input logic [2:0] s, input logic [4:0] fl,
                                input logic [1:0] rc);
        vec_t t;
        t.rst = r; t.en = e; t.lk = l; t.vld = v; t.rv = a; t.ov = o; t.uv = u; t.fe = f;
        t.st = s; t.fl = fl; t.rc = rc;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] est, input logic [4:0] efl,
                         input logic [1:0] erc);
        logic [4:0] afl;
        afl = {lockin_en, rate_en, clear_st, locked, fault};
        checks++;
        if (state !== est || afl !== efl || retry !== erc) begin
            errors++;
            $display("FAIL %s: got state=%0d flags=%b retry=%0d, want state=%0d flags=%b retry=%0d",
                     name, state, afl, retry, est, efl, erc);
        end
    endtask

    task automatic clear_pulses();
        rv = 0; ov = 0; uv = 0; fe = 0;
    endtask

    // From IDLE: two FLUSH cycles then ACQUIRE with retry 0.
    task automatic start_run(input string tag);
        en = 1;
        tick(); check({tag, "_flush1"}, 3'd1, FFlush, 2'd0);
        tick(); check({tag, "_flush2"}, 3'd1, FFlush, 2'd0);
        tick(); check({tag, "_acq"}, 3'd2, FAcq, 2'd0);
    endtask

    initial begin
        rst = 1; en = 0; lk = 0; vld = 0; rv = 0; ov = 0; uv = 0; fe = 0;
        acq_to = 16'd10; rel_to = 16'd8;

        // rst en lk vld rv ov uv fe | state flags retry
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, FIdle, 2'd0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd1, FFlush, 2'd0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd1, FFlush, 2'd0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd2, FAcq, 2'd0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd2, FAcq, 2'd0));
        // lock at ACQUIRE cycle 5
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 3'd3, FLock, 2'd0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 3'd3, FLock, 2'd0));
        // 3 violations then a clean event: stays locked
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 3'd3, FLock, 2'd0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 3'd3, FLock, 2'd0));
        // 4 consecutive violations: RELOCK
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 3'd3, FLock, 2'd0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 3'd4, FRelock, 2'd0));
        // lock with a violation in the same cycle does not return
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 3'd4, FRelock, 2'd0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd4, FRelock, 2'd0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 3'd3, FLock, 2'd0));
        // lock lost: RELOCK, then 8-cycle relock timeout
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd4, FRelock, 2'd0));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd4, FRelock, 2'd0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd1, FFlush, 2'd1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd1, FFlush, 2'd1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd2, FAcq, 2'd1));
        // successful acquisition clears the retry count
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 3'd3, FLock, 2'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; en = tbl[i].en; lk = tbl[i].lk; vld = tbl[i].vld;
            rv = tbl[i].rv; ov = tbl[i].ov; uv = tbl[i].uv; fe = tbl[i].fe;
            tick();
            check($sformatf("vec%0d", i), tbl[i].st, tbl[i].fl, tbl[i].rc);
        end

        // Retry exhaustion: four 10-cycle ACQUIRE timeouts end in FAULT.
        clear_pulses(); lk = 0; vld = 0; en = 0;
        tick(); check("to_idle", 3'd0, FIdle, 2'd0);
        start_run("retry");
        for (int k = 1; k <= 4; k++) begin
            for (int c = 0; c < 9; c++) begin
                tick(); check($sformatf("acq_run%0d_c%0d", k, c), 3'd2, FAcq, 2'(k - 1));
            end
            tick();
            if (k < 4) begin
                check($sformatf("acq_fail%0d", k), 3'd1, FFlush, 2'(k));
                tick(); check($sformatf("reflush%0d", k), 3'd1, FFlush, 2'(k));
                tick(); check($sformatf("reacq%0d", k), 3'd2, FAcq, 2'(k));
            end else begin
                check("fault_enter", 3'd5, FFault, 2'd3);
            end
        end
        for (int c = 0; c < 3; c++) begin
            tick(); check("fault_hold", 3'd5, FFault, 2'd3);
        end
        en = 0;
        tick(); check("fault_exit", 3'd0, FIdle, 2'd0);

        // Zero timeout never fires; a timeout below the running timer never matches.
        acq_to = 16'd0;
        start_run("noto");
        for (int c = 0; c < 20; c++) begin
            tick(); check("noto_acq", 3'd2, FAcq, 2'd0);
        end
        acq_to = 16'd5;
        for (int c = 0; c < 5; c++) begin
            tick(); check("low_to_acq", 3'd2, FAcq, 2'd0);
        end
        en = 0;
        tick(); check("noto_idle", 3'd0, FIdle, 2'd0);

        // Rate violation and lock in the same ACQUIRE cycle: fail wins.
        acq_to = 16'd10;
        start_run("simul");
        rv = 1; lk = 1; vld = 1;
        tick(); check("rv_vs_lock", 3'd1, FFlush, 2'd1);
        clear_pulses(); lk = 0; vld = 0;
        // Enable dropped mid-FLUSH.
        en = 0;
        tick(); check("en_drop_flush", 3'd0, FIdle, 2'd0);

        // Reset while LOCKED, with enable still high.
        start_run("rst");
        lk = 1; vld = 1;
        tick(); check("rst_locked", 3'd3, FLock, 2'd0);
        rst = 1;
        tick(); check("rst_clear", 3'd0, FIdle, 2'd0);
        rst = 0; en = 0; lk = 0; vld = 0;
        tick(); check("post_rst", 3'd0, FIdle, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
